wrap_counter_p: RTL
===================

Name: wrap_counter_p

Overview:
Parametrised bounded modulo counter, the general successor of the fixed 1..12 clock-style counter. It supports runtime lower and upper bounds, up/down counting, wrap or saturate mode, synchronous range-checked load, and a combinational carry for cascading into hour/minute/second chains. It sits between the time-base enable generator and display/compare logic, and several instances chain via carry_out -> enable.

Parameters:
WIDTH, 4, counter width in bits; bounds, load value and Q are all WIDTH bits, unsigned.
RESET_VAL, 1, value of Q after reset; must be < 2^WIDTH.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  count step request for this cycle.
up  input  1  1 = count up, 0 = count down.
sat_mode  input  1  1 = saturate at bound, 0 = wrap to opposite bound.
lo  input  WIDTH  runtime lower bound, inclusive.
hi  input  WIDTH  runtime upper bound, inclusive.
load  input  1  synchronous load request.
load_val  input  WIDTH  value to load.
Q  output  WIDTH  registered count.
carry_out  output  1  combinational; high when this cycle's step wraps; feeds next stage's enable.
at_limit  output  1  combinational; Q at the bound in the current direction (Q>=hi when up, Q<=lo when down).
wrapped  output  1  registered one-cycle pulse, set the cycle after a wrap.
load_err  output  1  registered one-cycle pulse, set the cycle after an out-of-range load.
cfg_err  output  1  combinational; lo > hi.

Behaviour:
- Reset (async, any time, including mid-count): Q=RESET_VAL, wrapped=0, load_err=0. Combinational outputs follow from Q and inputs.
- Priority per rising edge: cfg_err > load > enable > hold.
- cfg_err=1: Q holds; load and enable ignored; carry_out=0; wrapped/load_err=0 next cycle.
- load=1 (cfg ok):
  - Q <= load_val if lo<=load_val<=hi.
  - Otherwise Q <= lo (load_val<lo) or hi (load_val>hi), and load_err=1 next cycle.
  - enable ignored that cycle; carry_out=0.
- enable=1, load=0, up=1:
  - Q<hi and Q>=lo: Q<=Q+1.
  - Q>=hi: wrap mode gives Q<=lo, carry_out=1, wrapped=1 next cycle; sat mode gives Q<=hi, carry_out=0.
  - Q<lo (bounds moved under Q): Q<=lo, carry_out=0.
- enable=1, load=0, up=0: mirror case.
  - Q>lo and Q<=hi: Q<=Q-1.
  - Q<=lo: wrap mode gives Q<=hi, carry_out=1, wrapped=1; sat mode gives Q<=lo.
  - Q>hi: Q<=hi, carry_out=0.
- enable=0: Q holds; carry_out=0; wrapped=0 next cycle.
- lo==hi: wrap mode steps Q<=lo with carry_out=1 on every enabled cycle.
- No arithmetic overflow: increments only occur when Q<hi<=2^WIDTH-1, and decrements only when Q>lo>=0.
- Latency: Q updates one cycle after the request. carry_out is valid in the same cycle as the enable that causes the wrap, so a chained stage steps on the same edge.
- Bounds may change on any cycle; they are sampled at each edge with no internal copy.

Test Plan:
1. Reset mid-count: WIDTH=4, lo=1, hi=12, Q=7; assert reset asynchronously between edges -> Q=1 immediately; wrapped=0.
2. Up wrap: lo=1, hi=12, up=1, sat_mode=0, enable continuous from Q=11 -> Q sequence 12, 1, 2. carry_out=1 only in the cycle Q=12. wrapped=1 in the cycle Q=1.
3. Down saturate: lo=1, hi=12, up=0, sat_mode=1, Q=2, enable continuous -> Q goes 1, 1, 1. at_limit=1 from Q=1 onward; carry_out stays 0.
4. Load range check: lo=1, hi=12; load_val=15 with load=1 and enable=1 -> Q=12, load_err=1 for one cycle. Then load_val=0 -> Q=1, load_err=1. Then load_val=5 -> Q=5, load_err=0.
5. Config error and bound move: Q=10, then set lo=9, hi=3 -> cfg_err=1 and Q stays 10 under enable and load. Then set lo=0, hi=5 with up=1 -> next enabled edge Q=0 and carry_out=1.
6. Cascade: two instances with stage A at lo=0, hi=9 and A.carry_out driving B.enable, B at lo=0, hi=5, both starting at 0 -> after 60 enabled cycles both are 0. B.carry_out is high exactly once, in the cycle with A=9, B=5.

Source files
------------

// File: rtl/wrap_counter_p.sv
//============================================================================
// Module      : wrap_counter_p
// Description : Bounded modulo counter with runtime lower/upper bounds,
//               up/down counting, wrap or saturate mode, range-checked
//               synchronous load and a combinational carry for cascading.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   enable     step request for this cycle (chain input)
//   up         1 = count up, 0 = count down
//   sat_mode   1 = saturate at bound, 0 = wrap to opposite bound
//   lo, hi     inclusive runtime bounds (unsigned, WIDTH bits)
//   load       synchronous load request
//   load_val   value to load (clamped into [lo, hi])
//   Q          registered count
//   carry_out  combinational, high when this cycle's step wraps
//   at_limit   combinational, Q at the bound in the current direction
//   wrapped    registered one-cycle pulse after a wrap
//   load_err   registered one-cycle pulse after an out-of-range load
//   cfg_err    combinational, lo > hi
//
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module wrap_counter_p #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             carry_out,
  output logic             at_limit,
  output logic             wrapped,
  output logic             load_err,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] c_reset_val = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrapped;
  logic             r_load_err;

  logic [WIDTH-1:0] w_next;
  logic             w_carry;
  logic             w_load_err;
  logic             w_cfg_err;

  assign w_cfg_err = (lo > hi);

  // Next-state selection. Priority: bad config > load > enable > hold.
  // With lo <= hi guaranteed past the first branch, the "below lo" and
  // "at/above hi" tests in each direction are mutually exclusive, and
  // +1 / -1 only happen strictly inside the bounds, so no overflow.
  always_comb begin
    w_next     = r_q;
    w_carry    = 1'b0;
    w_load_err = 1'b0;
    if (w_cfg_err) begin
      w_next = r_q;
    end else if (load) begin
      if (load_val < lo) begin
        w_next     = lo;
        w_load_err = 1'b1;
      end else if (load_val > hi) begin
        w_next     = hi;
        w_load_err = 1'b1;
      end else begin
        w_next = load_val;
      end
    end else if (enable) begin
      if (up) begin
        if (r_q < lo) begin
          // bounds moved above the count: snap in, no carry
          w_next = lo;
        end else if (r_q >= hi) begin
          if (sat_mode) begin
            w_next = hi;
          end else begin
            w_next  = lo;
            w_carry = 1'b1;
          end
        end else begin
          w_next = r_q + c_one;
        end
      end else begin
        if (r_q > hi) begin
          // bounds moved below the count: snap in, no carry
          w_next = hi;
        end else if (r_q <= lo) begin
          if (sat_mode) begin
            w_next = lo;
          end else begin
            w_next  = hi;
            w_carry = 1'b1;
          end
        end else begin
          w_next = r_q - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q        <= c_reset_val;
      r_wrapped  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= w_next;
      r_wrapped  <= w_carry;
      r_load_err <= w_load_err;
    end
  end

  assign Q         = r_q;
  assign carry_out = w_carry;
  assign at_limit  = up ? (r_q >= hi) : (r_q <= lo);
  assign wrapped   = r_wrapped;
  assign load_err  = r_load_err;
  assign cfg_err   = w_cfg_err;

endmodule

`default_nettype wire
